rd_data_resp_arbiter: RTL and testbench
=======================================

Name: rd_data_resp_arbiter

Overview:
- Arbitrates M upstream read-data response lanes onto N per-master response ports, routing by in_pld[i].txnid.master_id.
- Removes the "no two lanes target the same master in one cycle" restriction of the combinational master decode:
  - conflicting lanes are serialized by a per-master round-robin arbiter;
  - losers are backpressured through in_rdy.
- Each master port has a registered output stage with valid/ready.
- Sits between the cache read-data pipes and the upstream master interfaces.

Parameters:
- M, 8, number of upstream response lanes.
- N, 16, number of master ports; master_id width is $clog2(N).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_vld  input  [M-1:0]  lane valid.
- in_pld  input  us_data_pld_t [M-1:0]  lane payload (vector_cache_pkg); the routing key is txnid.master_id.
- in_rdy  output  [M-1:0]  lane accepted this cycle.
- out_vld  output  [N-1:0]  master port valid.
- out_pld  output  us_data_pld_t [N-1:0]  master port payload.
- out_rdy  input  [N-1:0]  master port ready.
- err_bad_id  output  1  sticky flag: a valid lane presented master_id >= N.

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low (rst_n); all state clears immediately on assertion.
- Reset values:
  - out_vld = 0, out_pld = '0;
  - rr_ptr[j] = 0 for all j;
  - err_bad_id = 0;
  - in_rdy = 0 (combinational, follows from empty arbitration).
- Request matrix (combinational): req[j][i] = in_vld[i] && (in_pld[i].txnid.master_id == j).
- Slot availability: slot_free[j] = !out_vld[j] || out_rdy[j]. A full slot accepts a new beat in the same cycle it is drained.
- Grant:
  - When slot_free[j], grant the first requesting lane i scanning from rr_ptr[j] upward, wrapping modulo M.
  - At most one grant per master per cycle.
  - Each lane targets exactly one master, so each lane receives at most one grant.
- in_rdy[i] = 1 iff lane i is granted this cycle. It is purely combinational from in_vld, in_pld, out_vld, out_rdy and rr_ptr. There is no combinational path from in_rdy back into grant.
- On grant to lane i for master j:
  - next cycle out_vld[j] = 1, out_pld[j] = in_pld[i];
  - rr_ptr[j] <= (i+1) mod M.
- If slot_free[j] with no request: out_vld[j] <= 0. rr_ptr[j] is unchanged.
- If out_vld[j] && !out_rdy[j]: out_vld[j] and out_pld[j] hold stable; no grant for j.
- Latency: one cycle from accepted input to out_vld. Throughput is one beat per master per cycle; up to min(M,N) beats total per cycle.
- Fairness: a lane continuously requesting master j is granted within M grants to j.
- Upstream rules:
  - In-lane order is preserved.
  - in_pld[i] must be held stable while in_vld[i] && !in_rdy[i].
  - Beats from different lanes to the same master may be reordered; this is legal because txnid identifies the transaction.
- master_id >= N (only possible when N is not a power of two):
  - the lane never gets a grant and stalls;
  - err_bad_id is set the same cycle's next edge and stays 1 until reset.
- Simultaneous events:
  - Drain and refill of the same slot in one cycle is allowed; the new beat appears on the next cycle with no bubble.
  - Independent masters arbitrate fully in parallel.
- Reset mid-operation: in-flight registered beats are discarded; upstream must re-present.

Test Plan:
- Single lane, no conflict:
  - Stimulus: lane 2 valid, master_id=5, out_rdy=all 1.
  - Response: in_rdy[2]=1 the same cycle; next cycle out_vld[5]=1 with out_pld[5]=lane 2 payload; all other out_vld=0.
- Full conflict:
  - Stimulus: lanes 0..7 all valid, all master_id=3, held, out_rdy[3]=1.
  - Response: grants in order 0,1,...,7 over 8 consecutive cycles, one per cycle; out_vld[3] continuous for 8 cycles; rr_ptr[3] returns to 0.
- Round-robin pointer:
  - Stimulus: grant lane 5 to master 0, then lanes 1 and 6 request master 0.
  - Response: lane 6 is granted first, then lane 1.
- Backpressure:
  - Stimulus: out_vld[7]=1 with out_rdy[7]=0 for 4 cycles, lane 1 requesting master 7.
  - Response: in_rdy[1]=0 and out_pld[7] stable for those 4 cycles. In the cycle out_rdy[7] rises, in_rdy[1]=1 and the next payload appears with no bubble.
- Parallel routing:
  - Stimulus: lanes 0..7 target masters 8..15 respectively.
  - Response: all in_rdy=1 in one cycle; next cycle out_vld[15:8]=8'hFF.
- Bad id and reset:
  - Stimulus: N=12, lane 4 presents master_id=13.
  - Response: in_rdy[4] stays 0 and err_bad_id=1 sticky. Asserting rst_n=0 mid-burst immediately clears out_vld, err_bad_id and all rr_ptr.

Source files
------------

// File: rtl/rd_data_resp_arbiter.sv
// Read-data response crossbar: M cache lanes onto N master ports, routed by txnid.master_id.
// Each master port has its own round-robin arbiter and a one-entry registered output slot.
package vector_cache_pkg;
    localparam int MID_W = 4;

    typedef struct packed {
        logic [MID_W-1:0] master_id;
        logic [7:0]       tag;
    } txnid_t;

    typedef struct packed {
        txnid_t      txnid;
        logic [31:0] data;
        logic        last;
    } us_data_pld_t;
endpackage

// One master port: round-robin pick among requesting lanes, then a registered valid/ready slot.
module rd_data_resp_slot
    import vector_cache_pkg::*;
#(
    parameter int M = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [M-1:0]             req,
    input  us_data_pld_t [M-1:0]     in_pld,
    input  logic                     out_rdy,
    output logic [M-1:0]             gnt,
    output logic                     out_vld,
    output us_data_pld_t             out_pld
);
    localparam int PW = (M > 1) ? $clog2(M) : 1;

    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          out_vld_q, out_vld_d;
    us_data_pld_t  out_pld_q, out_pld_d;
    logic          slot_free, found;
    logic [PW-1:0] sel, idx;

    always_comb begin
        slot_free = !out_vld_q || out_rdy;
        found     = 1'b0;
        sel       = '0;
        idx       = '0;
        // Scan from the pointer upward so the last winner gets lowest priority.
        for (int k = 0; k < M; k++) begin
            idx = PW'((int'(rr_ptr_q) + k) % M);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end

        gnt       = '0;
        out_vld_d = out_vld_q;
        out_pld_d = out_pld_q;
        rr_ptr_d  = rr_ptr_q;
        if (slot_free) begin
            out_vld_d = found;
            if (found) begin
                gnt[sel]  = 1'b1;
                out_pld_d = in_pld[sel];
                rr_ptr_d  = (sel == PW'(M - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            out_vld_q <= 1'b0;
            out_pld_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            out_vld_q <= out_vld_d;
            out_pld_q <= out_pld_d;
        end
    end

    assign out_vld = out_vld_q;
    assign out_pld = out_pld_q;
endmodule

module rd_data_resp_arbiter
    import vector_cache_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [M-1:0]         in_vld,
    input  us_data_pld_t [M-1:0] in_pld,
    output logic [M-1:0]         in_rdy,
    output logic [N-1:0]         out_vld,
    output us_data_pld_t [N-1:0] out_pld,
    input  logic [N-1:0]         out_rdy,
    output logic                 err_bad_id
);
    localparam int MW = MID_W;

    logic [N-1:0][M-1:0] req;
    logic [N-1:0][M-1:0] gnt;
    logic                bad_any;
    logic                err_bad_id_q, err_bad_id_d;

    always_comb begin
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < M; i++) begin
                req[j][i] = in_vld[i] && (in_pld[i].txnid.master_id == MW'(j));
            end
        end
    end

    // An out-of-range id matches no row of req, so the lane simply never wins.
    always_comb begin
        bad_any = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (in_vld[i] && ({1'b0, in_pld[i].txnid.master_id} >= (MW + 1)'(N)))
                bad_any = 1'b1;
        end
        err_bad_id_d = err_bad_id_q || bad_any;
    end

    always_comb begin
        in_rdy = '0;
        for (int j = 0; j < N; j++) in_rdy = in_rdy | gnt[j];
    end

    for (genvar j = 0; j < N; j++) begin : g_slot
        rd_data_resp_slot #(.M(M)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (req[j]),
            .in_pld  (in_pld),
            .out_rdy (out_rdy[j]),
            .gnt     (gnt[j]),
            .out_vld (out_vld[j]),
            .out_pld (out_pld[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_bad_id_q <= 1'b0;
        else        err_bad_id_q <= err_bad_id_d;
    end

    assign err_bad_id = err_bad_id_q;
endmodule

// File: tb/tb_rd_data_resp_arbiter.sv
// Random traffic against a per-master queue model, plus directed bad-id/reset checks on an N=12 instance.
module tb_rd_data_resp_arbiter;
    import vector_cache_pkg::*;

    localparam int M  = 8;
    localparam int N  = 16;
    localparam int NB = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic b_rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [M-1:0]         in_vld = '0;
    us_data_pld_t [M-1:0] in_pld = '0;
    logic [M-1:0]         in_rdy;
    logic [N-1:0]         out_vld;
    us_data_pld_t [N-1:0] out_pld;
    logic [N-1:0]         out_rdy = '0;
    logic                 err;

    logic [M-1:0]          b_in_vld = '0;
    us_data_pld_t [M-1:0]  b_in_pld = '0;
    logic [M-1:0]          b_in_rdy;
    logic [NB-1:0]         b_out_vld;
    us_data_pld_t [NB-1:0] b_out_pld;
    logic [NB-1:0]         b_out_rdy = '1;
    logic                  b_err;

    rd_data_resp_arbiter #(.M(M), .N(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_pld(in_pld), .in_rdy(in_rdy),
        .out_vld(out_vld), .out_pld(out_pld), .out_rdy(out_rdy), .err_bad_id(err)
    );

    rd_data_resp_arbiter #(.M(M), .N(NB)) u_bad (
        .clk(clk), .rst_n(b_rst_n), .in_vld(b_in_vld), .in_pld(b_in_pld), .in_rdy(b_in_rdy),
        .out_vld(b_out_vld), .out_pld(b_out_pld), .out_rdy(b_out_rdy), .err_bad_id(b_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic us_data_pld_t mk(input int mid, input logic [7:0] tag);
        us_data_pld_t p;
        p.txnid.master_id = MID_W'(mid);
        p.txnid.tag       = tag;
        p.data            = $urandom;
        p.last            = 1'($urandom_range(1));
        return p;
    endfunction

    // Reference state: per-master expected beats, occupancy and round-robin pointer.
    us_data_pld_t exp_q[N][$];
    bit           occ[N];
    int           rr[N];
    bit           lane_v[M];
    us_data_pld_t lane_p[M];
    logic [7:0]   tagc[M];
    bit           mon_en = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                for (int j = 0; j < N; j++) begin
                    chk($sformatf("out_vld[%0d]", j), 64'(out_vld[j]), 64'(exp_q[j].size() != 0));
                    if (out_vld[j] && out_rdy[j] && exp_q[j].size() != 0)
                        chk($sformatf("out_pld[%0d]", j), 64'(out_pld[j]), 64'(exp_q[j].pop_front()));
                end
            end
        end
    end

    task automatic cycle(input int mode, input int vprob, input int rprob);
        logic [M-1:0] eg;
        us_data_pld_t pend[N];
        bit           pv[N];
        bit           free;
        int           mid, i;
        @(negedge clk);
        #1;
        for (int l = 0; l < M; l++) begin
            if (!lane_v[l] && int'($urandom_range(99)) < vprob) begin
                mid = (mode == 0) ? int'($urandom_range(N - 1)) : (mode == 1) ? 3 : 8 + l;
                lane_v[l] = 1'b1;
                lane_p[l] = mk(mid, tagc[l]);
                tagc[l]++;
            end
            in_vld[l] = lane_v[l];
            in_pld[l] = lane_p[l];
        end
        for (int j = 0; j < N; j++) out_rdy[j] = (int'($urandom_range(99)) < rprob);
        #1;
        eg = '0;
        for (int j = 0; j < N; j++) begin
            free  = !occ[j] || out_rdy[j];
            pv[j] = 1'b0;
            if (free) begin
                for (int k = 0; k < M; k++) begin
                    i = (rr[j] + k) % M;
                    if (!pv[j] && lane_v[i] && int'(lane_p[i].txnid.master_id) == j) begin
                        pv[j]   = 1'b1;
                        eg[i]   = 1'b1;
                        pend[j] = lane_p[i];
                        rr[j]   = (i + 1) % M;
                    end
                end
            end
            occ[j] = pv[j] || !free;
        end
        chk("in_rdy", 64'(in_rdy), 64'(eg));
        @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) if (pv[j]) exp_q[j].push_back(pend[j]);
        for (int l = 0; l < M; l++) if (eg[l]) lane_v[l] = 1'b0;
    endtask

    us_data_pld_t p5, p6;

    initial begin
        for (int l = 0; l < M; l++) tagc[l] = 8'(l << 5);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_vld", 64'(out_vld), 64'(0));
        chk("rst_in_rdy", 64'(in_rdy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        @(negedge clk);
        rst_n   = 1'b1;
        b_rst_n = 1'b1;

        // Bad id on N=12 instance, round-robin order, then async reset mid-operation.
        @(negedge clk); #1;
        p5 = mk(0, 8'h55);
        b_in_pld[4] = mk(13, 8'h44);
        b_in_pld[5] = p5;
        b_in_vld    = 8'h30;
        #1 chk("bad_rdy0", 64'(b_in_rdy), 64'h20);
        @(posedge clk); #1;
        chk("bad_err_set", 64'(b_err), 64'(1));
        chk("bad_out_vld", 64'(b_out_vld), 64'h001);
        chk("bad_out_pld", 64'(b_out_pld[0]), 64'(p5));
        b_in_vld[5] = 1'b0;
        @(negedge clk); #1;
        p6 = mk(0, 8'h66);
        b_in_pld[6] = p6;
        b_in_pld[1] = mk(0, 8'h11);
        b_in_vld    = b_in_vld | 8'h42;
        #1 chk("rr_first", 64'(b_in_rdy), 64'h40);
        @(posedge clk); #1;
        chk("rr_first_pld", 64'(b_out_pld[0]), 64'(p6));
        b_in_vld[6] = 1'b0;
        @(negedge clk); #2;
        chk("rr_second", 64'(b_in_rdy), 64'h02);
        @(posedge clk); #1;
        b_in_vld[1] = 1'b0;
        chk("bad_lane_stall", 64'(b_in_rdy[4]), 64'(0));
        b_in_vld[4] = 1'b0;
        @(negedge clk); #1;
        chk("bad_err_sticky", 64'(b_err), 64'(1));
        b_in_vld = 8'h20;
        @(posedge clk); #1;
        b_in_vld = '0;
        @(negedge clk); #1;
        b_in_vld[4] = 1'b1;
        b_rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", 64'(b_out_vld), 64'(0));
        chk("rst_mid_err", 64'(b_err), 64'(0));
        @(negedge clk); #1;
        b_in_vld = '0;
        b_rst_n  = 1'b1;
        b_in_vld = 8'h42;
        #1 chk("rr_after_rst", 64'(b_in_rdy), 64'h02);
        @(posedge clk); #1;
        b_in_vld = '0;
        chk("err_after_rst", 64'(b_err), 64'(0));

        // Randomised traffic on the main instance.
        mon_en = 1'b1;
        repeat (300) cycle(0, 60, 70);
        repeat (200) cycle(1, 90, 50);
        repeat (100) cycle(2, 90, 100);
        repeat (200) cycle(0, 80, 30);
        repeat (30) cycle(0, 0, 100);
        @(negedge clk); #4;
        mon_en = 1'b0;
        for (int j = 0; j < N; j++) chk($sformatf("drained[%0d]", j), 64'(exp_q[j].size()), 64'(0));
        chk("final_out_vld", 64'(out_vld), 64'(0));
        chk("final_err", 64'(err), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
